decoder3to8_hold: RTL and testbench

//  Receiving end of the 8-to-3 priority encoder link. Accepts encoder words {a,gs,eo} over a

---
 rtl/enc_dec_pkg.sv | 23 ++
 rtl/decoder3to8_hold_if.sv | 14 +
 rtl/decoder3to8_hold_sync_fifo.sv | 54 +++++
 rtl/decoder3to8_hold.sv | 103 ++++++++++
 tb/tb_decoder3to8_hold.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/enc_dec_pkg.sv
// Shared definitions for the priority-encoder link: word layout, line decode and FSM states.
package enc_dec_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;
  localparam logic [LINES-1:0] Y_IDLE = 8'hFF;

  typedef enum logic {IDLE, DRIVE} state_t;

  typedef struct packed {
    logic [CODE_W-1:0] a;
    logic              gs;
    logic              eo;
  } enc_word_t;

  // Encoder index is active-low: a=3'b000 selects line 7.
  function automatic logic [LINES-1:0] decode_line(input logic [CODE_W-1:0] a);
    logic [CODE_W-1:0] idx;
    idx = ~a;
    return ~(LINES'(1) << idx);
  endfunction

endpackage

// File: rtl/decoder3to8_hold_if.sv
// Valid/ready link carrying encoder words {a, gs, eo} into the decoder.
interface decoder3to8_hold_if;
  import enc_dec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] a;
  logic              gs;
  logic              eo;

  modport master (output in_valid, a, gs, eo, input in_ready);
  modport slave  (input in_valid, a, gs, eo, output in_ready);

endinterface

// File: rtl/decoder3to8_hold_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers wrap naturally, a separate count gives full/empty.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decoder3to8_hold.sv
// Receives encoder words, buffers them and drives each request as an active-low line
// held for HOLD_CYCLES cycles.
//   state | meaning
//   IDLE  | y_n released (8'hFF); pops the next buffered word
//   DRIVE | one line held low while cnt counts down; at cnt==0 chains the next word
module decoder3to8_hold
  import enc_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  decoder3to8_hold_if.slave       link,
  output logic [LINES-1:0]        y_n,
  output logic                    busy,
  output logic                    none_p,
  output logic                    dis_p,
  output logic                    err_p
);

  localparam int WW = $bits(enc_word_t);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [LINES-1:0] y_d;
  logic             none_d, dis_d, err_d;
  logic             pop;
  logic             full, empty;
  logic [WW-1:0]    rdata;
  enc_word_t        head;

  assign link.in_ready = !full;
  assign head          = enc_word_t'(rdata);

  sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (link.in_valid && !full),
    .wdata ({link.a, link.gs, link.eo}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_n     <= Y_IDLE;
      none_p  <= 1'b0;
      dis_p   <= 1'b0;
      err_p   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_n     <= y_d;
      none_p  <= none_d;
      dis_p   <= dis_d;
      err_p   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_n;
    none_d  = 1'b0;
    dis_d   = 1'b0;
    err_d   = 1'b0;
    pop     = 1'b0;

    // A pop is taken from IDLE, or from DRIVE once the current hold has expired.
    if (!empty && (state_q == IDLE || cnt_q == 8'd0)) begin
      pop = 1'b1;
      if (!head.gs) begin
        y_d     = decode_line(head.a);
        cnt_d   = 8'(HOLD_CYCLES - 1);
        state_d = DRIVE;
        err_d   = !head.eo;
      end else begin
        y_d     = Y_IDLE;
        state_d = IDLE;
        none_d  = !head.eo;
        dis_d   = head.eo;
      end
    end else if (state_q == DRIVE) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        y_d     = Y_IDLE;
        state_d = IDLE;
      end
    end
  end

  assign busy = (state_q == DRIVE);

endmodule

// File: tb/tb_decoder3to8_hold.sv
// Directed bench for decoder3to8_hold (HOLD_CYCLES=4, FIFO_DEPTH=2).
module tb_decoder3to8_hold;

  logic       clk;
  logic       rst;
  logic [7:0] y_n;
  logic       busy, none_p, dis_p, err_p;

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  logic [7:0] trace [$];
  bit         rec = 1'b0;

  decoder3to8_hold_if dif ();

  decoder3to8_hold #(
    .HOLD_CYCLES (4),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .link   (dif.slave),
    .y_n    (y_n),
    .busy   (busy),
    .none_p (none_p),
    .dis_p  (dis_p),
    .err_p  (err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rec) trace.push_back(y_n);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] a, input logic gs, input logic eo);
    dif.in_valid = v;
    dif.a        = a;
    dif.gs       = gs;
    dif.eo       = eo;
  endtask

  // Checks y_n (and busy) on n consecutive negedges, ending one negedge later.
  task automatic expect_run(input string tag, input logic [7:0] val, input logic bsy, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, y_n, val);
      check({tag, "_busy"}, busy, bsy);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] run_val [$];
    int         run_len [$];
    logic [7:0] prev;
    logic [7:0] exp4 [4];
    int         guard;
    int         bad;

    drive(1'b0, 3'b000, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset / idle
    repeat (5) @(negedge clk);
    check("t1_y_n", y_n, 8'hFF);
    check("t1_busy", busy, 1'b0);
    check("t1_none", none_p, 1'b0);
    check("t1_dis", dis_p, 1'b0);
    check("t1_err", err_p, 1'b0);
    check("t1_ready", dif.in_ready, 1'b1);

    // 2: single request a=000 -> line 7
    drive(1'b1, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    check("t2_latency", y_n, 8'hFF);
    @(negedge clk);
    expect_run("t2_drive", 8'h7F, 1'b1, 4);
    check("t2_release", y_n, 8'hFF);
    check("t2_release_busy", busy, 1'b0);
    repeat (2) @(negedge clk);

    // 3: back-to-back, no gap
    drive(1'b1, 3'b111, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'b101, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    expect_run("t3_first", 8'hFE, 1'b1, 4);
    expect_run("t3_second", 8'hFB, 1'b1, 4);
    check("t3_release", y_n, 8'hFF);
    repeat (2) @(negedge clk);

    // 4: backpressure with in_valid held
    trace.delete();
    rec = 1'b1;
    check("t4_ready0", dif.in_ready, 1'b1);
    drive(1'b1, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_ready1", dif.in_ready, 1'b1);
    drive(1'b1, 3'b001, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_ready2", dif.in_ready, 1'b1);
    drive(1'b1, 3'b010, 1'b0, 1'b1);
    @(negedge clk);
    check("t4_full", dif.in_ready, 1'b0);
    drive(1'b1, 3'b011, 1'b0, 1'b1);
    guard = 0;
    while (!dif.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("t4_ready_return", dif.in_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    rec = 1'b0;
    prev = 8'hFF;
    foreach (trace[i]) begin
      if (trace[i] != 8'hFF) begin
        if (trace[i] != prev) begin
          run_val.push_back(trace[i]);
          run_len.push_back(1);
        end else begin
          run_len[run_len.size()-1]++;
        end
      end
      prev = trace[i];
    end
    exp4[0] = 8'h7F; exp4[1] = 8'hBF; exp4[2] = 8'hDF; exp4[3] = 8'hEF;
    check("t4_run_count", run_val.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t4_order", (i < run_val.size()) ? run_val[i] : 8'hxx, exp4[i]);
      check("t4_hold_len", (i < run_len.size()) ? run_len[i] : -1, 4);
    end
    check("t4_idle_end", y_n, 8'hFF);

    // 5: status pulses
    drive(1'b1, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b000, 1'b1, 1'b1);
    check("t5_none_early", none_p, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b011, 1'b0, 1'b0);
    check("t5_none", none_p, 1'b1);
    check("t5_none_y", y_n, 8'hFF);
    check("t5_none_dis", dis_p, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    check("t5_dis", dis_p, 1'b1);
    check("t5_dis_none", none_p, 1'b0);
    check("t5_dis_y", y_n, 8'hFF);
    @(negedge clk);
    check("t5_err", err_p, 1'b1);
    check("t5_err_dis", dis_p, 1'b0);
    check("t5_err_y", y_n, 8'hEF);
    check("t5_err_busy", busy, 1'b1);
    @(negedge clk);
    check("t5_err_clear", err_p, 1'b0);
    check("t5_err_hold", y_n, 8'hEF);
    repeat (6) @(negedge clk);
    check("t5_release", y_n, 8'hFF);

    // 6: reset mid-drive flushes buffered words
    drive(1'b1, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'b001, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'b010, 1'b0, 1'b1);
    check("t6_drive1", y_n, 8'h7F);
    @(negedge clk);
    drive(1'b0, 3'b000, 1'b1, 1'b0);
    check("t6_drive2", y_n, 8'h7F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_y", y_n, 8'hFF);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ready", dif.in_ready, 1'b1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (y_n != 8'hFF || busy) bad++;
      @(negedge clk);
    end
    check("t6_no_stale_decode", bad, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
